// File: rtl/nibble_seq_proc_pkg.sv
// rtl/nibble_seq_proc_pkg.sv - shared op codes, state encoding and step count
package nibble_seq_proc_pkg;

  typedef enum logic [1:0] {
    OP_SUM = 2'd0,
    OP_XOR = 2'd1,
    OP_MAX = 2'd2,
    OP_MIN = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int RUN_STEPS = 3;

endpackage

// File: rtl/nibble_combine.sv
// rtl/nibble_combine.sv - combinational single-step reduction of two operands
module nibble_combine
  import nibble_seq_proc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    y    = a;
    cout = 1'b0;
    case (op)
      OP_SUM: begin
        y    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
      OP_XOR: y = a ^ b;
      OP_MAX: y = (b > a) ? b : a;
      OP_MIN: y = (b < a) ? b : a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/nibble_seq_proc.sv
// rtl/nibble_seq_proc.sv - captures four operands on start and reduces them one per clock
module nibble_seq_proc
  import nibble_seq_proc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             ack,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             proc,
  output logic             rdy
);

  localparam logic [1:0] LAST_STEP = 2'(RUN_STEPS);

  state_e           state_q, state_d;
  logic             accept;
  logic [1:0]       cnt_q;
  op_e              op_q;
  logic [WIDTH-1:0] cap_q [3];
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] step_y;
  logic             step_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // start takes priority over ack in DONE so a back-to-back run never idles
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) accept = 1'b1;
      ST_RUN:  if (cnt_q == LAST_STEP) state_d = ST_DONE;
      ST_DONE: begin
        if (start)    accept  = 1'b1;
        else if (ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) state_d = ST_RUN;
  end

  always_comb begin
    operand = cap_q[2];
    case (cnt_q)
      2'd1:    operand = cap_q[0];
      2'd2:    operand = cap_q[1];
      default: operand = cap_q[2];
    endcase
  end

  nibble_combine #(.WIDTH(WIDTH)) u_combine (
    .a    (acc_q),
    .b    (operand),
    .op   (op_q),
    .y    (step_y),
    .cout (step_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      op_q    <= OP_SUM;
      acc_q   <= '0;
      carry_q <= 1'b0;
      out     <= '0;
      ovf     <= 1'b0;
      for (int i = 0; i < 3; i++) cap_q[i] <= '0;
    end else if (accept) begin
      cap_q[0] <= in2;
      cap_q[1] <= in3;
      cap_q[2] <= in4;
      op_q     <= op_e'(op);
      acc_q    <= in1;
      carry_q  <= 1'b0;
      cnt_q    <= 2'd1;
    end else if (state_q == ST_RUN) begin
      acc_q   <= step_y;
      carry_q <= carry_q | step_cout;
      cnt_q   <= cnt_q + 2'd1;
      if (cnt_q == LAST_STEP) begin
        out   <= step_y;
        ovf   <= carry_q | step_cout;
        cnt_q <= '0;
      end
    end
  end

  assign proc = (state_q == ST_RUN);
  assign rdy  = (state_q == ST_DONE);

endmodule

// File: tb/tb_nibble_seq_proc.sv
// tb/tb_nibble_seq_proc.sv - self-checking bench for nibble_seq_proc
module tb_nibble_seq_proc;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic             ack;
  logic [WIDTH-1:0] in1, in2, in3, in4;
  logic [WIDTH-1:0] out;
  logic             ovf, proc, rdy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a, b, c, d;
    logic [3:0] y;
    logic       v;
  } vec_t;

  typedef struct {
    logic [3:0] y;
    logic       v;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  nibble_seq_proc #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .ack   (ack),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3),
    .in4   (in4),
    .out   (out),
    .ovf   (ovf),
    .proc  (proc),
    .rdy   (rdy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [3:0] a, b, c, d);
    logic [4:0] s;
    logic [3:0] v[4];
    exp_t r;
    v = '{a, b, c, d};
    r.y = a;
    r.v = 1'b0;
    for (int i = 1; i < 4; i++) begin
      case (o)
        2'd0: begin
          s = {1'b0, r.y} + {1'b0, v[i]};
          r.y = s[3:0];
          r.v = r.v | s[4];
        end
        2'd1: r.y = r.y ^ v[i];
        2'd2: if (v[i] > r.y) r.y = v[i];
        default: if (v[i] < r.y) r.y = v[i];
      endcase
    end
    return r;
  endfunction

  task automatic set_in(input logic [1:0] o, input logic [3:0] a, b, c, d);
    op = o; in1 = a; in2 = b; in3 = c; in4 = d;
  endtask

  task automatic launch(input logic [1:0] o, input logic [3:0] a, b, c, d);
    set_in(o, a, b, c, d);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // call right after the accept edge; counts proc cycles until rdy and scores the result
  task automatic finish_run(input string name);
    int   n;
    exp_t e;
    n = 1;
    chk({name, "_proc_after_accept"}, proc, 1);
    for (int k = 0; k < 10 && !rdy; k++) begin
      tick();
      if (proc) n++;
    end
    chk({name, "_proc_cycles"}, n, 3);
    chk({name, "_rdy"}, rdy, 1);
    if (sb.size() == 0) begin
      chk({name, "_scoreboard_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({name, "_out"}, out, e.y);
      chk({name, "_ovf"}, ovf, e.v);
    end
  endtask

  task automatic do_ack(input string name);
    logic [3:0] held;
    held = out;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({name, "_rdy_after_ack"}, rdy, 0);
    chk({name, "_proc_after_ack"}, proc, 0);
    chk({name, "_out_kept"}, out, held);
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{2'd0, 4'h9, 4'h8, 4'h3, 4'h1, 4'h5, 1'b1};
    vecs[1] = '{2'd1, 4'hA, 4'h5, 4'hF, 4'h1, 4'h1, 1'b0};
    vecs[2] = '{2'd2, 4'h3, 4'hC, 4'h7, 4'hC, 4'hC, 1'b0};
    vecs[3] = '{2'd3, 4'h3, 4'hC, 4'h7, 4'hC, 4'h3, 1'b0};
    vecs[4] = '{2'd0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 1'b0};
    vecs[5] = '{2'd0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hC, 1'b1};
    vecs[6] = '{2'd3, 4'h6, 4'h6, 4'h6, 4'h6, 4'h6, 1'b0};
    vecs[7] = '{2'd2, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0};
    vecs[8] = '{2'd1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 1'b0};
    vecs[9] = '{2'd0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 1'b1};

    rst_n = 1'b0; start = 1'b0; ack = 1'b0;
    set_in(2'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick(); tick();
    chk("reset_out", out, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_proc", proc, 0);
    chk("reset_rdy", rdy, 0);
    rst_n = 1'b1;
    tick();

    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("idle_ack_ignored_proc", proc, 0);
    chk("idle_ack_ignored_rdy", rdy, 0);

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
      e.y = vecs[i].y;
      e.v = vecs[i].v;
      sb.push_back(e);
      finish_run($sformatf("vec%0d", i));
      do_ack($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      logic [1:0] o;
      logic [3:0] a, b, c, d;
      o = 2'($urandom_range(0, 3));
      a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
      launch(o, a, b, c, d);
      sb.push_back(model(o, a, b, c, d));
      finish_run($sformatf("rnd%0d", i));
      do_ack($sformatf("rnd%0d", i));
    end

    // operand and op changes after the accept edge must not reach the result
    launch(2'd0, 4'h1, 4'h2, 4'h3, 4'h4);
    e.y = 4'hA; e.v = 1'b0;
    sb.push_back(e);
    in2 = 4'hF; op = 2'd1;
    finish_run("capture_iso");
    do_ack("capture_iso");

    set_in(2'd0, 4'h1, 4'h1, 4'h1, 4'h1);
    start = 1'b1;
    tick();
    chk("held_start_proc_t0", proc, 1);
    tick();
    chk("held_start_proc_t1", proc, 1);
    tick();
    chk("held_start_proc_t2", proc, 1);
    chk("held_start_rdy_t2", rdy, 0);
    tick();
    chk("held_start_rdy_t3", rdy, 1);
    chk("held_start_proc_t3", proc, 0);
    chk("held_start_out", out, 4);
    tick();
    start = 1'b0;
    chk("held_start_reaccept_rdy", rdy, 0);
    e.y = 4'h4; e.v = 1'b0;
    sb.push_back(e);
    finish_run("held_start_second");

    set_in(2'd1, 4'h1, 4'h2, 4'h4, 4'h8);
    start = 1'b1; ack = 1'b1;
    tick();
    start = 1'b0; ack = 1'b0;
    chk("start_ack_rdy", rdy, 0);
    e.y = 4'hF; e.v = 1'b0;
    sb.push_back(e);
    finish_run("start_ack");
    do_ack("start_ack");

    launch(2'd0, 4'h3, 4'h3, 4'h3, 4'h3);
    tick(); tick();
    chk("pre_reset_proc", proc, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_proc", proc, 0);
    chk("midrun_reset_rdy", rdy, 0);
    chk("midrun_reset_out", out, 0);
    chk("midrun_reset_ovf", ovf, 0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post_reset_idle_proc%0d", k), proc, 0);
      chk($sformatf("post_reset_idle_rdy%0d", k), rdy, 0);
    end

    launch(2'd2, 4'h5, 4'h9, 4'h2, 4'h7);
    e.y = 4'h9; e.v = 1'b0;
    sb.push_back(e);
    finish_run("no_ack");
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("no_ack_rdy%0d", k), rdy, 1);
      chk($sformatf("no_ack_out%0d", k), out, 9);
    end
    do_ack("no_ack");

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
